action_ram_ctrl: RTL and testbench
==================================

Name: action_ram_ctrl

Overview:
- Owns the per-stage action RAM that feeds the crossbar/ALU stage with one ACT_LEN*NUM_ACT-bit action word per PHV.
- Assembles wide action entries from a 32-bit configuration stream and arbitrates the single RAM port between lookup reads and configuration commits.
- Guarantees that configuration commits cannot be starved by back-to-back lookups.
- Sits between the match/lookup result and the crossbar's action input, with back-pressure from the crossbar's ready.

Parameters:
- STAGE_ID, 0, stage number matched against config header.
- ACT_LEN, 25, bits per container action.
- NUM_ACT, 25, container actions per entry; ENTRY_W = ACT_LEN*NUM_ACT = 625.
- ADDR_W, 5, entry address width; depth 2**ADDR_W = 32.
- CFG_W, 32, config word width; NUM_WORDS = ceil(ENTRY_W/CFG_W) = 20.
- MAX_WAIT, 4, cycles a pending commit may be blocked before it pre-empts lookups.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config word valid.
- cfg_data  in  CFG_W  config word.
- cfg_ready  out  1  config word accepted when cfg_valid&cfg_ready.
- lkp_valid  in  1  lookup request.
- lkp_hit  in  1  match hit; 0 means miss.
- lkp_addr  in  ADDR_W  entry index.
- lkp_ready  out  1  lookup accepted when lkp_valid&lkp_ready.
- action_out  out  ENTRY_W  action word to crossbar.
- action_valid_out  out  1  action_out valid.
- ready_in  in  1  crossbar ready.
- entry_valid  out  2**ADDR_W  per-entry written flag (debug/CSR).

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - cfg_ready=1, action_valid_out=0, action_out=0, entry_valid=0, word counter=0, wait counter=0.
  - RAM contents are not cleared.
- Config packet format:
  - Header word: [31:28] stage, [27:24] opcode, [ADDR_W-1:0] address.
  - Opcode 1 (WRITE): followed by NUM_WORDS data words. The first data word is the most significant (bits 639:608 of a 640-bit assembly). The entry is the low ENTRY_W bits; the top 15 bits are discarded.
  - Opcode 2 (CLEAR): header only; clears entry_valid[addr] one cycle after acceptance. RAM is not written.
  - Other opcodes: header only; ignored.
  - Stage mismatch on a WRITE: the following NUM_WORDS words are consumed and dropped.
- FSM states:
  - IDLE: on an accepted header, decode. WRITE with matching stage -> LOAD. WRITE with mismatch -> DROP. CLEAR with matching stage -> executes clear, stays IDLE. Otherwise stay IDLE.
  - LOAD: shifts in each accepted word. After the NUM_WORDS-th word -> COMMIT; cfg_ready=0.
  - DROP: counts NUM_WORDS accepted words -> IDLE.
  - COMMIT: requests the RAM port. Once granted, writes the entry, sets entry_valid[addr], cfg_ready=1 -> IDLE.
- Arbitration (one RAM port per cycle):
  - Lookup has priority while wait counter < MAX_WAIT.
  - The wait counter increments each COMMIT cycle in which a lookup holds the port.
  - At MAX_WAIT, grant goes to the commit and lkp_ready=0 for that cycle.
  - The commit is also granted in any cycle with no accepted lookup.
  - The wait counter clears on grant.
  - lkp_ready = ready_in & ~commit_grant.
- Lookup pipeline:
  - Latency is 1 cycle: a lookup accepted at cycle N gives action_valid_out=1 with the data at N+1.
  - action_out = RAM[addr] if lkp_hit & entry_valid[addr]; otherwise all zeros (no-op action).
  - The output register updates only when ready_in=1. With ready_in=0, action_out and action_valid_out hold, and no lookup is accepted.
  - With ready_in=1 and no lookup accepted, action_valid_out goes to 0 on the next cycle.
- Hazards:
  - A commit and a lookup never share a cycle.
  - A lookup accepted the cycle after a commit to the same address returns the new data.
  - A CLEAR and a lookup to the same address in the same cycle: the lookup returns the old state; the next lookup returns zeros.
- Reset mid-packet: the partially loaded entry is discarded, no RAM write occurs, and the FSM is in IDLE next cycle.

Test Plan:
- Write entry at addr 3 with words 0x00000000..0x00000013, then lookup addr 3 hit -> action_out equals the low 625 bits of the concatenation; action_valid_out high exactly 1 cycle after acceptance.
- Lookup addr 7 (never written) with hit=1, and addr 3 with hit=0 -> action_out=0, valid=1.
- Header with stage=STAGE_ID+1, opcode 1, plus 20 words, then a valid write to addr 5 -> addr 5 is correct, entry_valid has only bit 5 (plus any earlier bits) set, and no write from the dropped packet.
- Continuous lkp_valid=1, ready_in=1 during COMMIT -> lkp_ready drops for exactly 1 cycle after 4 blocked cycles; the commit lands; the following lookup returns the new data.
- ready_in=0 for 3 cycles with valid output pending -> action_out/action_valid_out stable, lkp_ready=0; resume -> no lost or duplicated outputs.
- Assert rst after the 10th data word, then send a full write to the same addr -> only the second packet's data is read back; CLEAR addr 3 -> the next lookup of 3 returns 0.

Source files
------------

// File: rtl/action_ram_ctrl.sv
// action_ram_ctrl
//   Owns the per-stage action RAM. Wide action entries are assembled from a
//   32-bit configuration stream and committed through the single RAM port,
//   which is shared with lookup reads. A commit blocked by lookups for
//   MAX_WAIT cycles pre-empts the lookup path for one cycle.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cfg_valid/ready   config word handshake, cfg_data = word
//   lkp_valid/ready   lookup handshake; lkp_hit=0 means miss, lkp_addr = entry
//   action_out        ENTRY_W-bit action word to crossbar, qualified by
//                     action_valid_out, advanced only when ready_in=1
//   entry_valid       per-entry written flag
module action_ram_ctrl #(
  parameter int unsigned STAGE_ID = 0,
  parameter int unsigned ACT_LEN  = 25,
  parameter int unsigned NUM_ACT  = 25,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned CFG_W    = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  input  logic [CFG_W-1:0]           cfg_data,
  output logic                       cfg_ready,
  input  logic                       lkp_valid,
  input  logic                       lkp_hit,
  input  logic [ADDR_W-1:0]          lkp_addr,
  output logic                       lkp_ready,
  output logic [ACT_LEN*NUM_ACT-1:0] action_out,
  output logic                       action_valid_out,
  input  logic                       ready_in,
  output logic [2**ADDR_W-1:0]       entry_valid
);

  localparam int unsigned ENTRY_W   = ACT_LEN * NUM_ACT;
  localparam int unsigned NUM_WORDS = (ENTRY_W + CFG_W - 1) / CFG_W;
  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam int unsigned CNT_W     = $clog2(NUM_WORDS + 1);
  localparam int unsigned WAIT_W    = $clog2(MAX_WAIT + 1);

  localparam logic [3:0]        STAGE_TAG = 4'(STAGE_ID);
  localparam logic [3:0]        OP_WRITE  = 4'd1;
  localparam logic [3:0]        OP_CLEAR  = 4'd2;
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(NUM_WORDS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DROP,
    S_COMMIT
  } state_e;

  state_e              state_q;
  logic                cfg_ready_q;
  logic [CNT_W-1:0]    word_cnt_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ENTRY_W-1:0]  asm_q;
  logic [ENTRY_W-1:0]  asm_d;
  logic [DEPTH-1:0]    entry_valid_q;
  logic [ENTRY_W-1:0]  action_q;
  logic                action_valid_q;
  logic [ENTRY_W-1:0]  ram_q [DEPTH];

  logic                cfg_acc;
  logic                lkp_acc;
  logic                commit_grant;
  logic [3:0]          hdr_stage;
  logic [3:0]          hdr_op;
  logic [ADDR_W-1:0]   hdr_addr;
  logic [ENTRY_W-1:0]  lkp_rd_data;

  assign hdr_stage = cfg_data[CFG_W-1 -: 4];
  assign hdr_op    = cfg_data[CFG_W-5 -: 4];
  assign hdr_addr  = cfg_data[ADDR_W-1:0];

  // First word lands most significant; keeping only ENTRY_W bits drops the
  // unused top bits of the final assembly as words shift through.
  assign asm_d = {asm_q[ENTRY_W-CFG_W-1:0], cfg_data};

  // The commit takes the port once it has waited long enough, or whenever no
  // lookup could be accepted this cycle. Gated by rst so a commit in flight
  // never writes during reset.
  assign commit_grant = ~rst && (state_q == S_COMMIT) &&
                        ((wait_q >= WAIT_LIM) || !(lkp_valid && ready_in));

  assign lkp_ready = ready_in & ~commit_grant;
  assign lkp_acc   = lkp_valid & lkp_ready;
  assign cfg_acc   = cfg_valid & cfg_ready_q;

  // Same-cycle CLEAR is not yet visible here, so a colliding lookup sees the
  // old state.
  assign lkp_rd_data = (lkp_hit && entry_valid_q[lkp_addr]) ? ram_q[lkp_addr] : '0;

  assign cfg_ready        = cfg_ready_q;
  assign action_out       = action_q;
  assign action_valid_out = action_valid_q;
  assign entry_valid      = entry_valid_q;

  always_ff @(posedge clk) begin
    if (commit_grant) begin
      ram_q[addr_q] <= asm_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cfg_ready_q    <= 1'b1;
      word_cnt_q     <= '0;
      wait_q         <= '0;
      addr_q         <= '0;
      entry_valid_q  <= '0;
      action_q       <= '0;
      action_valid_q <= 1'b0;
    end else begin
      if (ready_in) begin
        action_valid_q <= lkp_acc;
        if (lkp_acc) begin
          action_q <= lkp_rd_data;
        end
      end

      unique case (state_q)
        S_IDLE: begin
          if (cfg_acc) begin
            if (hdr_op == OP_WRITE) begin
              word_cnt_q <= '0;
              addr_q     <= hdr_addr;
              state_q    <= (hdr_stage == STAGE_TAG) ? S_LOAD : S_DROP;
            end else if (hdr_op == OP_CLEAR && hdr_stage == STAGE_TAG) begin
              entry_valid_q[hdr_addr] <= 1'b0;
            end
          end
        end

        S_LOAD: begin
          if (cfg_acc) begin
            asm_q <= asm_d;
            if (word_cnt_q == LAST_WORD) begin
              word_cnt_q  <= '0;
              wait_q      <= '0;
              cfg_ready_q <= 1'b0;
              state_q     <= S_COMMIT;
            end else begin
              word_cnt_q <= word_cnt_q + 1'b1;
            end
          end
        end

        S_DROP: begin
          if (cfg_acc) begin
            if (word_cnt_q == LAST_WORD) begin
              word_cnt_q <= '0;
              state_q    <= S_IDLE;
            end else begin
              word_cnt_q <= word_cnt_q + 1'b1;
            end
          end
        end

        S_COMMIT: begin
          if (commit_grant) begin
            entry_valid_q[addr_q] <= 1'b1;
            wait_q                <= '0;
            cfg_ready_q           <= 1'b1;
            state_q               <= S_IDLE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_action_ram_ctrl.sv
// Randomized bench for action_ram_ctrl with a packet-level reference model:
// config words are parsed into packets held in queues, entries are rebuilt by
// placing words into their bit positions, and the port arbitration is predicted
// from the pending-commit age.
module tb_action_ram_ctrl;

  localparam int unsigned ENTRY_W = 625;
  localparam int unsigned NW      = 20;
  localparam int          MAXW    = 4;
  localparam logic [3:0]  STG     = 4'd0;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_valid = 1'b0;
  logic [31:0]        cfg_data = '0;
  logic               cfg_ready;
  logic               lkp_valid = 1'b0;
  logic               lkp_hit = 1'b0;
  logic [4:0]         lkp_addr = '0;
  logic               lkp_ready;
  logic [ENTRY_W-1:0] action_out;
  logic               action_valid_out;
  logic               ready_in = 1'b0;
  logic [31:0]        entry_valid;

  action_ram_ctrl #(
    .STAGE_ID (0),
    .ACT_LEN  (25),
    .NUM_ACT  (25),
    .ADDR_W   (5),
    .CFG_W    (32),
    .MAX_WAIT (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_valid        (cfg_valid),
    .cfg_data         (cfg_data),
    .cfg_ready        (cfg_ready),
    .lkp_valid        (lkp_valid),
    .lkp_hit          (lkp_hit),
    .lkp_addr         (lkp_addr),
    .lkp_ready        (lkp_ready),
    .action_out       (action_out),
    .action_valid_out (action_valid_out),
    .ready_in         (ready_in),
    .entry_valid      (entry_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [ENTRY_W-1:0] m_mem [32];
  logic [31:0]        m_ev = '0;
  bit                 m_vld = 1'b0;
  logic [ENTRY_W-1:0] m_act = '0;
  int                 m_left = 0;
  bit                 m_drop = 1'b0;
  bit                 m_pending = 1'b0;
  int                 m_blocked = 0;
  logic [4:0]         m_addr = '0;
  logic [31:0]        m_words[$];

  // Stimulus knobs (percentages) and bookkeeping
  logic [31:0] cfgq[$];
  int g_cfg_p = 100, g_lv_p = 0, g_hit_p = 100, g_rdy_p = 100, g_addr = -1;
  int pops = 0;
  int lkp_stall_obs = 0;

  function automatic logic [ENTRY_W-1:0] build_entry();
    logic [639:0] full;
    full = '0;
    for (int i = 0; i < NW; i++) full[(NW-1-i)*32 +: 32] = m_words[i];
    return full[ENTRY_W-1:0];
  endfunction

  task automatic step(input bit r);
    bit cv, lv, lh, rdy, exp_cfg_rdy, exp_grant, exp_lkp_rdy, lkp_acc, cfg_acc;
    logic [4:0]  la;
    logic [31:0] cd;
    cv  = !r && cfgq.size() > 0 && int'($urandom_range(99)) < g_cfg_p;
    lv  = !r && int'($urandom_range(99)) < g_lv_p;
    lh  = int'($urandom_range(99)) < g_hit_p;
    rdy = int'($urandom_range(99)) < g_rdy_p;
    la  = (g_addr < 0) ? 5'($urandom_range(31)) : 5'(g_addr);
    cd  = cv ? cfgq[0] : $urandom();
    @(negedge clk);
    rst = r; cfg_valid = cv; cfg_data = cd;
    lkp_valid = lv; lkp_hit = lh; lkp_addr = la; ready_in = rdy;
    #1;
    if (r) begin
      m_ev = '0; m_vld = 1'b0; m_act = '0; m_left = 0; m_drop = 1'b0;
      m_pending = 1'b0; m_blocked = 0; m_words.delete();
    end else begin
      exp_cfg_rdy = !m_pending;
      exp_grant   = m_pending && (m_blocked >= MAXW || !(lv && rdy));
      exp_lkp_rdy = rdy && !exp_grant;
      check_eq("cfg_ready", cfg_ready, exp_cfg_rdy);
      check_eq("lkp_ready", lkp_ready, exp_lkp_rdy);
      if (lv && rdy && !lkp_ready) lkp_stall_obs++;
      lkp_acc = lv && exp_lkp_rdy;
      cfg_acc = cv && exp_cfg_rdy;
      if (rdy) begin
        m_vld = lkp_acc;
        if (lkp_acc) m_act = (lh && m_ev[la]) ? m_mem[la] : '0;
      end
      if (exp_grant) begin
        m_mem[m_addr] = build_entry();
        m_ev[m_addr]  = 1'b1;
        m_pending = 1'b0;
        m_blocked = 0;
      end else if (m_pending) begin
        m_blocked++;
      end
      if (cfg_acc) begin
        void'(cfgq.pop_front());
        pops++;
        if (m_left > 0) begin
          if (!m_drop) m_words.push_back(cd);
          m_left--;
          if (m_left == 0 && !m_drop) m_pending = 1'b1;
        end else if (cd[27:24] == 4'd1) begin
          m_left = NW;
          m_drop = (cd[31:28] != STG);
          m_addr = cd[4:0];
          m_words.delete();
        end else if (cd[27:24] == 4'd2 && cd[31:28] == STG) begin
          m_ev[cd[4:0]] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    check_eq("action_valid_out", action_valid_out, m_vld);
    if (m_vld) check_eq("action_out", action_out, m_act);
    check_eq("entry_valid", entry_valid, m_ev);
  endtask

  task automatic push_write(input logic [3:0] stg, input logic [4:0] a, input bit seq);
    cfgq.push_back({stg, 4'd1, 19'($urandom), a});
    for (int i = 0; i < NW; i++) cfgq.push_back(seq ? 32'(i) : $urandom());
  endtask

  task automatic drain(input int limit);
    int  n;
    bit  busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < limit) begin
      step(1'b0);
      n++;
      busy = cfgq.size() > 0 || m_pending || m_left > 0;
    end
    check_eq("drain_done", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [639:0]       full1;
    logic [ENTRY_W-1:0] exp1;
    logic [ENTRY_W-1:0] held;
    int n;

    full1 = '0;
    for (int i = 0; i < NW; i++) full1[(NW-1-i)*32 +: 32] = 32'(i);
    exp1 = full1[ENTRY_W-1:0];

    // Reset state
    step(1'b1);
    step(1'b1);
    check_eq("rst_action_out", action_out, 0);
    check_eq("rst_cfg_ready", cfg_ready, 1);

    // Sequential-word write to addr 3, then hit lookup
    push_write(STG, 5'd3, 1'b1);
    drain(100);
    g_lv_p = 100; g_addr = 3; g_hit_p = 100; g_rdy_p = 100;
    step(1'b0);
    check_eq("t1_valid", action_valid_out, 1);
    check_eq("t1_data", action_out, exp1);
    g_lv_p = 0;
    step(1'b0);
    check_eq("t1_valid_drop", action_valid_out, 0);

    // Unwritten entry and miss both return a no-op action
    g_lv_p = 100; g_addr = 7; g_hit_p = 100;
    step(1'b0);
    check_eq("t2_unwritten", action_out, 0);
    g_addr = 3; g_hit_p = 0;
    step(1'b0);
    check_eq("t2_miss", action_out, 0);

    // Foreign-stage packet dropped, then valid write to addr 5
    g_lv_p = 30; g_addr = -1; g_hit_p = 70;
    push_write(STG + 4'd1, 5'd5, 1'b0);
    push_write(STG, 5'd5, 1'b0);
    drain(300);
    check_eq("t3_entry_valid", entry_valid, 32'h0000_0028);

    // Commit under continuous lookups
    g_lv_p = 100; g_addr = 9; g_hit_p = 100; g_rdy_p = 100;
    lkp_stall_obs = 0;
    push_write(STG, 5'd9, 1'b0);
    drain(200);
    for (int i = 0; i < 3; i++) step(1'b0);
    check_eq("t4_stall_cycles", lkp_stall_obs, 1);

    // Back-pressure holds the output
    step(1'b0);
    held = action_out;
    g_rdy_p = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      check_eq("t5_hold_data", action_out, held);
      check_eq("t5_hold_valid", action_valid_out, 1);
    end
    g_rdy_p = 100;
    for (int i = 0; i < 3; i++) step(1'b0);

    // Reset after the 10th data word, then a full write to the same address
    g_lv_p = 0;
    push_write(STG, 5'd12, 1'b0);
    pops = 0;
    n = 0;
    while (pops < 11 && n < 100) begin
      step(1'b0);
      n++;
    end
    check_eq("t6_partial_words", pops, 11);
    step(1'b1);
    cfgq.delete();
    push_write(STG, 5'd12, 1'b0);
    drain(100);
    g_lv_p = 100; g_addr = 12; g_hit_p = 100;
    step(1'b0);
    step(1'b0);

    // CLEAR colliding with a lookup of the same address
    g_lv_p = 0;
    push_write(STG, 5'd3, 1'b1);
    drain(100);
    cfgq.push_back({STG, 4'd2, 19'd0, 5'd3});
    g_lv_p = 100; g_addr = 3; g_hit_p = 100; g_rdy_p = 100; g_cfg_p = 100;
    step(1'b0);
    check_eq("t7_clear_same_cycle", action_out, exp1);
    step(1'b0);
    check_eq("t7_clear_after", action_out, 0);
    check_eq("t7_entry_cleared", entry_valid[3], 0);

    // Random traffic
    g_addr = -1;
    for (int p = 0; p < 40; p++) begin
      int kind;
      logic [4:0] a;
      a = 5'($urandom_range(7));
      kind = int'($urandom_range(9));
      if (kind < 6) push_write(STG, a, 1'b0);
      else if (kind < 7) push_write(STG + 4'd1, a, 1'b0);
      else if (kind < 9) cfgq.push_back({STG, 4'd2, 19'($urandom), a});
      else cfgq.push_back({STG, 4'd3, 19'($urandom), a});
      g_cfg_p = 50 + int'($urandom_range(50));
      g_lv_p  = int'($urandom_range(100));
      g_hit_p = 80;
      g_rdy_p = 60 + int'($urandom_range(40));
      drain(400);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
